// File: rtl/dram_rr_arbiter.sv
// Round-robin arbiter sharing one DRAM command port and read-return port among N_REQ lanes.
// Grants are acked combinationally and land in the command slot one cycle later; a held slot blocks all grants.
module dram_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ABW   = 32,
  parameter int DBW   = 16,
  parameter int CSIZE = 32,
  parameter int DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_REQ-1:0]             i_ra_rdys,
  output logic [N_REQ-1:0]             o_ra_acks,
  input  logic [N_REQ*ABW-1:0]         i_ra_addrs,
  input  logic [N_REQ-1:0]             i_w_rdys,
  output logic [N_REQ-1:0]             o_w_acks,
  input  logic [N_REQ*ABW-1:0]         i_w_addrs,
  input  logic [N_REQ*CSIZE*DBW-1:0]   i_w_datas,
  output logic                         o_cmd_rdy,
  input  logic                         i_cmd_ack,
  output logic                         o_cmd_write,
  output logic [ABW-1:0]               o_cmd_addr,
  output logic [CSIZE*DBW-1:0]         o_cmd_wdata,
  input  logic                         i_rd_rdy,
  output logic                         o_rd_ack,
  input  logic [CSIZE*DBW-1:0]         i_rd_data,
  output logic [N_REQ-1:0]             o_rd_rdys,
  input  logic [N_REQ-1:0]             i_rd_acks,
  output logic [CSIZE*DBW-1:0]         o_rd_data,
  output logic                         o_err
);

  localparam int LW = CSIZE * DBW;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(N_REQ - 1);

  logic [PW-1:0]    rr_ptr, win, win_hi, win_lo;
  logic             found_hi, found_lo, found;
  logic             slot_free, rd_ok, grant, win_write;
  logic [N_REQ-1:0] elig;
  logic [ABW-1:0]   win_addr;
  logic [LW-1:0]    win_data;

  logic [PW-1:0]    tags [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [PW-1:0]    head;
  logic             not_empty, push, pop;

  assign slot_free = !o_cmd_rdy || i_cmd_ack;
  // Reads are throttled on the registered count only; a same-cycle pop does not open a slot.
  assign rd_ok     = count < DEPTH_C;
  assign elig      = i_w_rdys | (i_ra_rdys & {N_REQ{rd_ok}});

  // Lowest eligible lane at/after the pointer wins, otherwise wrap to lowest eligible overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig[i] && (PW'(i) >= rr_ptr)) begin
        found_hi = 1'b1;
        win_hi   = PW'(i);
      end
      if (elig[i]) begin
        found_lo = 1'b1;
        win_lo   = PW'(i);
      end
    end
    found = found_lo;
    win   = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    win_write = 1'b0;
    win_addr  = '0;
    win_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PW'(i)) begin
        win_write = i_w_rdys[i];
        win_addr  = i_w_rdys[i] ? i_w_addrs[i*ABW +: ABW] : i_ra_addrs[i*ABW +: ABW];
        win_data  = i_w_rdys[i] ? i_w_datas[i*LW +: LW] : '0;
      end
    end
  end

  assign grant = slot_free && found;

  always_comb begin
    o_w_acks  = '0;
    o_ra_acks = '0;
    o_rd_rdys = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_w_acks[i]  = grant && win_write && (win == PW'(i));
      o_ra_acks[i] = grant && !win_write && (win == PW'(i));
      o_rd_rdys[i] = not_empty && i_rd_rdy && (head == PW'(i));
    end
  end

  assign head      = tags[rd_ptr];
  assign not_empty = (count != '0);
  assign o_rd_ack  = not_empty && i_rd_acks[head];
  assign o_rd_data = i_rd_data;
  assign push      = grant && !win_write;
  assign pop       = o_rd_ack && i_rd_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cmd_rdy   <= 1'b0;
      o_cmd_write <= 1'b0;
      o_cmd_addr  <= '0;
      o_cmd_wdata <= '0;
      rr_ptr      <= '0;
    end else if (grant) begin
      o_cmd_rdy   <= 1'b1;
      o_cmd_write <= win_write;
      o_cmd_addr  <= win_addr;
      o_cmd_wdata <= win_data;
      rr_ptr      <= (win == LAST) ? '0 : win + 1'b1;
    end else if (slot_free) begin
      o_cmd_rdy   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (i_rd_rdy && !not_empty) o_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge i_clk) begin
    if (push) tags[wr_ptr] <= win;
  end

endmodule

// File: doc/dram_rr_arbiter.md
Name: dram_rr_arbiter

Overview:
Shares one DRAM command port and one read-return port among N_REQ tau lanes, each with its own read-address, write and read-data rdy/ack channels. Round-robin grants one command per cycle into a registered command slot. A tag FIFO records the requester of every issued read so in-order return data is steered back to that lane. Sits between the per-tau dramra/dramw/dramrd ports of Top_sd and the external DRAM model.

Parameters:
N_REQ, 4, number of requesters (tau lanes)
ABW, 32, global address width
DBW, 16, data word width
CSIZE, 32, words per DRAM line (write/read payload = CSIZE*DBW)
DEPTH, 8, max outstanding reads (tag FIFO depth, power of 2)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_ra_rdys  in  N_REQ  per-lane read-address request valid
o_ra_acks  out  N_REQ  per-lane read-address accept (one-hot or zero)
i_ra_addrs  in  N_REQ*ABW  per-lane read address
i_w_rdys  in  N_REQ  per-lane write request valid
o_w_acks  out  N_REQ  per-lane write accept (one-hot or zero)
i_w_addrs  in  N_REQ*ABW  per-lane write address
i_w_datas  in  N_REQ*CSIZE*DBW  per-lane write line
o_cmd_rdy  out  1  command slot valid
i_cmd_ack  in  1  DRAM accepts command
o_cmd_write  out  1  1=write, 0=read
o_cmd_addr  out  ABW  command address
o_cmd_wdata  out  CSIZE*DBW  write line (zero for reads)
i_rd_rdy  in  1  DRAM return data valid
o_rd_ack  out  1  return data accepted
i_rd_data  in  CSIZE*DBW  return line
o_rd_rdys  out  N_REQ  per-lane return valid (one-hot or zero)
i_rd_acks  in  N_REQ  per-lane return accept
o_rd_data  out  CSIZE*DBW  return line broadcast to all lanes
o_err  out  1  sticky protocol error

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: o_cmd_rdy=0, o_cmd_write=0, o_cmd_addr=0, o_cmd_wdata=0, o_err=0, RR pointer=0, FIFO empty; all acks/rdys low. Reset mid-operation drops any held command and outstanding tags.
- Handshake: transfer when rdy&ack in same cycle. rdy, once high, holds with stable payload until ack. Ack may depend combinationally on rdy.
- Slot free = !o_cmd_rdy | i_cmd_ack. Grant only when slot free.
- Lane eligible if i_w_rdys[i], or i_ra_rdys[i] with reads allowed. Reads allowed iff FIFO count + (slot holds read not yet popped: n/a) < DEPTH; count taken from register, same-cycle pop ignored (conservative).
- Within a lane, write beats read. Across lanes, first eligible lane at or after RR pointer, wrapping modulo N_REQ.
- Grant cycle t: assert the single matching o_w_acks/o_ra_acks bit combinationally; at edge load slot (write flag, addr, data), o_cmd_rdy=1 from t+1; pointer <= winner+1 mod N_REQ. Read grant pushes winner ID into FIFO at same edge.
- No grant: pointer unchanged; if slot free, o_cmd_rdy <= 0. Sustained i_cmd_ack=1 gives 1 command/cycle.
- Return: FIFO non-empty -> o_rd_rdys[head] = i_rd_rdy, o_rd_ack = i_rd_acks[head]; transfer pops head. o_rd_data = i_rd_data, combinational pass-through, zero latency.
- Simultaneous push and pop: count unchanged, both pointers advance.
- i_rd_rdy=1 with FIFO empty: o_rd_ack=0, o_rd_rdys=0, o_err <= 1 (sticky until reset).
- Pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits.

Test Plan:
- Single read: lane2 ra_rdy, addr 0x100, cmd_ack=1 -> o_ra_acks=0100 at t, o_cmd_rdy/write=0/addr=0x100 at t+1; i_rd_rdy -> o_rd_rdys=0100, data passes through, FIFO empties.
- Fairness: all 4 lanes hold ra_rdy, cmd_ack=1 -> grants 0,1,2,3,0,... one per cycle; returns steered 0,1,2,3 in order.
- Write priority: lane1 w_rdy and ra_rdy both high -> write granted first (o_cmd_write=1), read next grant to lane1 only after other eligible lanes in RR order.
- Backpressure: cmd_ack=0 for 5 cycles with lanes requesting -> slot holds first command stable, no further acks; ack resumes -> next grant same cycle slot frees.
- FIFO full: 8 reads issued, no return -> 9th read not acked while write from lane3 still granted; one return pop -> read granted next cycle.
- Error/reset: i_rd_rdy with empty FIFO -> o_rd_ack=0, o_err=1 next edge; assert i_rst mid-stream with o_cmd_rdy=1 -> o_cmd_rdy=0, o_err=0 immediately.
